demo_scene_sequencer: RTL and testbench

Frame-synchronous controller that drives the `background_state` and `solid_color` configuration inputs of the pixel colour datapath. It steps through background scenes automatically on a frame count, accepts a user "next scene" request and a pause control, and animates the solid colour while scene 0 is active. All configuration changes are applied only at a frame boundary (vsync rising edge), so a frame never changes scene partway through.

---
 rtl/demo_scene_sequencer.sv | 176 +++++++++++++++++
 tb/tb_demo_scene_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demo_scene_sequencer.sv
// Frame-synchronous scene sequencer for the pixel colour datapath.
// Scene index and solid colour only ever change on a vsync rising edge.
module demo_scene_sequencer #(
    parameter int unsigned NUM_SCENES        = 12,
    parameter int unsigned FRAMES_PER_SCENE  = 240,
    parameter int unsigned COLOR_STEP_FRAMES = 8,
    parameter logic [5:0]  RESET_COLOR       = 6'h30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        next_btn,
    input  logic        hold,
    output logic [7:0]  background_state,
    output logic [5:0]  solid_color,
    output logic        scene_start,
    output logic [15:0] frame_in_scene
);

    localparam int unsigned SCENE_W = 8;
    localparam int unsigned COLOR_W = 6;
    localparam int unsigned FRAME_W = 16;
    localparam int unsigned DIV_W   = 8;

    localparam logic [SCENE_W-1:0] LAST_SCENE = SCENE_W'(NUM_SCENES - 1);
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAMES_PER_SCENE - 1);
    localparam logic [DIV_W-1:0]   LAST_DIV   = DIV_W'(COLOR_STEP_FRAMES - 1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic vsync_meta;
    logic vsync_sync;
    logic vsync_prev;
    logic sync_valid;
    logic vsync_armed;
    logic btn_meta;
    logic btn_sync;
    logic btn_prev;
    logic hold_meta;
    logic hold_sync;

    logic frame_tick;
    logic btn_rise;
    logic tick_accept;
    logic skip_pending;
    logic consume_skip;

    logic [DIV_W-1:0]   color_div;
    logic [DIV_W-1:0]   div_next;
    logic [SCENE_W-1:0] scene_next;
    logic [COLOR_W-1:0] color_next;
    logic [FRAME_W-1:0] frame_next;
    logic               start_next;

    // Input synchronizers. vsync_armed blocks a tick until vsync has really
    // been seen low after reset, so a vsync held high through reset is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_meta  <= 1'b0;
            vsync_sync  <= 1'b0;
            vsync_prev  <= 1'b0;
            sync_valid  <= 1'b0;
            vsync_armed <= 1'b0;
            btn_meta    <= 1'b0;
            btn_sync    <= 1'b0;
            btn_prev    <= 1'b0;
            hold_meta   <= 1'b0;
            hold_sync   <= 1'b0;
        end else begin
            vsync_meta  <= vsync;
            vsync_sync  <= vsync_meta;
            vsync_prev  <= vsync_sync;
            sync_valid  <= 1'b1;
            vsync_armed <= vsync_armed | (sync_valid & ~vsync_meta);
            btn_meta    <= next_btn;
            btn_sync    <= btn_meta;
            btn_prev    <= btn_sync;
            hold_meta   <= hold;
            hold_sync   <= hold_meta;
        end
    end

    assign frame_tick  = vsync_sync & ~vsync_prev & vsync_armed;
    assign btn_rise    = btn_sync & ~btn_prev;
    // A tick with hold low is processed both in RUN and when leaving PAUSE.
    assign tick_accept = frame_tick & ~hold_sync;

    // A fresh button edge in the consuming cycle re-arms the skip.
    always_ff @(posedge clk) begin
        if (rst) begin
            skip_pending <= 1'b0;
        end else begin
            skip_pending <= btn_rise | (skip_pending & ~consume_skip);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (frame_tick && hold_sync) begin
                    state_next = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (frame_tick && !hold_sync) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // Per-tick update of scene, frame count and colour animation.
    always_comb begin
        scene_next   = background_state;
        color_next   = solid_color;
        frame_next   = frame_in_scene;
        div_next     = color_div;
        start_next   = 1'b0;
        consume_skip = 1'b0;

        if (tick_accept && (skip_pending || frame_in_scene == LAST_FRAME)) begin
            scene_next   = (background_state == LAST_SCENE) ? SCENE_W'(0)
                                                            : background_state + SCENE_W'(1);
            frame_next   = FRAME_W'(0);
            div_next     = DIV_W'(0);
            start_next   = 1'b1;
            consume_skip = 1'b1;
            if (scene_next == SCENE_W'(0)) begin
                color_next = RESET_COLOR;
            end
        end else if (tick_accept) begin
            frame_next = frame_in_scene + FRAME_W'(1);
            if (background_state == SCENE_W'(0)) begin
                if (color_div == LAST_DIV) begin
                    div_next   = DIV_W'(0);
                    color_next = solid_color + COLOR_W'(1);
                end else begin
                    div_next   = color_div + DIV_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            background_state <= SCENE_W'(0);
            solid_color      <= RESET_COLOR;
            scene_start      <= 1'b0;
            frame_in_scene   <= FRAME_W'(0);
            color_div        <= DIV_W'(0);
        end else begin
            background_state <= scene_next;
            solid_color      <= color_next;
            scene_start      <= start_next;
            frame_in_scene   <= frame_next;
            color_div        <= div_next;
        end
    end

endmodule

// File: tb/tb_demo_scene_sequencer.sv
// Scoreboard bench for demo_scene_sequencer: directed vsync/button/hold
// stimulus queues expected output snapshots; monitors compare on each update.
module tb_demo_scene_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst      = 1'b1;
    logic vsync    = 1'b0;
    logic vsync2   = 1'b0;
    logic next_btn = 1'b0;
    logic hold     = 1'b0;

    logic [7:0]  bg1, bg2;
    logic [5:0]  col1, col2;
    logic        ss1, ss2;
    logic [15:0] fis1, fis2;

    demo_scene_sequencer #(
        .NUM_SCENES(4), .FRAMES_PER_SCENE(3), .COLOR_STEP_FRAMES(2), .RESET_COLOR(6'h30)
    ) dut (
        .clk(clk), .rst(rst), .vsync(vsync), .next_btn(next_btn), .hold(hold),
        .background_state(bg1), .solid_color(col1), .scene_start(ss1), .frame_in_scene(fis1)
    );

    // Long scene so the colour can run all the way round to the wrap.
    demo_scene_sequencer #(
        .NUM_SCENES(4), .FRAMES_PER_SCENE(100), .COLOR_STEP_FRAMES(2), .RESET_COLOR(6'h30)
    ) dut_wrap (
        .clk(clk), .rst(rst), .vsync(vsync2), .next_btn(1'b0), .hold(1'b0),
        .background_state(bg2), .solid_color(col2), .scene_start(ss2), .frame_in_scene(fis2)
    );

    typedef struct packed {
        logic [7:0]  bg;
        logic [5:0]  col;
        logic [15:0] fis;
        logic        ss;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic exp_t mk(input int bg, input int col, input int fis, input int ss);
        exp_t e;
        e.bg  = 8'(bg);
        e.col = 6'(col);
        e.fis = 16'(fis);
        e.ss  = 1'(ss);
        return e;
    endfunction

    function automatic void chk(input string nm, input exp_t got, input exp_t e);
        n_vec++;
        if (got !== e) begin
            n_err++;
            $display("FAIL %s vec%0d: got bg=%0d col=%h fis=%0d start=%b, required bg=%0d col=%h fis=%0d start=%b",
                     nm, n_vec, got.bg, got.col, got.fis, got.ss, e.bg, e.col, e.fis, e.ss);
        end
    endfunction

    // Reference model of when an output update is due: 2-stage sync of vsync,
    // rising edge, and no tick until vsync has been seen low after reset.
    logic m1_s1, m1_s2, m1_p, m1_arm, upd1;
    logic m2_s1, m2_s2, m2_p, m2_arm, upd2;

    always @(posedge clk) begin
        if (rst) begin
            m1_s1 <= 1'b0; m1_s2 <= 1'b0; m1_p <= 1'b0; m1_arm <= 1'b0; upd1 <= 1'b1;
            m2_s1 <= 1'b0; m2_s2 <= 1'b0; m2_p <= 1'b0; m2_arm <= 1'b0; upd2 <= 1'b0;
        end else begin
            m1_s1 <= vsync;  m1_s2 <= m1_s1; m1_p <= m1_s2; m1_arm <= m1_arm | ~vsync;
            upd1  <= m1_s2 & ~m1_p & m1_arm;
            m2_s1 <= vsync2; m2_s2 <= m2_s1; m2_p <= m2_s2; m2_arm <= m2_arm | ~vsync2;
            upd2  <= m2_s2 & ~m2_p & m2_arm;
        end
    end

    logic ss_chk1 = 1'b0;

    always @(negedge clk) begin
        exp_t g;
        exp_t e;
        g = {bg1, col1, fis1, ss1};
        if (ss_chk1) begin
            ss_chk1 = 1'b0;
            n_vec++;
            if (ss1 !== 1'b0) begin
                n_err++;
                $display("FAIL scene_start_width: got %b, required 0 one cycle after pulse", ss1);
            end
        end
        if (upd1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL dut_unexpected_update: got bg=%0d col=%h fis=%0d start=%b, required no update",
                         bg1, col1, fis1, ss1);
            end else begin
                e = q1.pop_front();
                chk("dut", g, e);
                if (e.ss) ss_chk1 = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        exp_t g;
        g = {bg2, col2, fis2, ss2};
        if (upd2 === 1'b1) begin
            if (q2.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wrap_unexpected_update: got col=%h fis=%0d, required no update", col2, fis2);
            end else begin
                chk("wrap", g, q2.pop_front());
            end
        end
    end

    task automatic frame1(input exp_t e);
        q1.push_back(e);
        @(negedge clk) vsync = 1'b1;
        repeat (6) @(negedge clk);
        vsync = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame2(input exp_t e);
        q2.push_back(e);
        @(negedge clk) vsync2 = 1'b1;
        repeat (6) @(negedge clk);
        vsync2 = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic btn_pulse();
        next_btn = 1'b1;
        repeat (4) @(negedge clk);
        next_btn = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        // Reset state
        q1.push_back(mk(0, 'h30, 0, 0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Colour wrap: 0x30 steps every 2 ticks, reaches 0x3F then 0x00
        for (int k = 1; k <= 32; k++) begin
            frame2(mk(0, (48 + k / 2) % 64, k, 0));
        end

        // Auto-advance, colour animation, wrap to scene 0 restores colour
        frame1(mk(0, 'h30, 1, 0));
        frame1(mk(0, 'h31, 2, 0));
        frame1(mk(1, 'h31, 0, 1));
        frame1(mk(1, 'h31, 1, 0));
        frame1(mk(1, 'h31, 2, 0));
        frame1(mk(2, 'h31, 0, 1));
        frame1(mk(2, 'h31, 1, 0));
        frame1(mk(2, 'h31, 2, 0));
        frame1(mk(3, 'h31, 0, 1));
        frame1(mk(3, 'h31, 1, 0));
        frame1(mk(3, 'h31, 2, 0));
        frame1(mk(0, 'h30, 0, 1));
        frame1(mk(0, 'h30, 1, 0));
        frame1(mk(0, 'h31, 2, 0));
        frame1(mk(1, 'h31, 0, 1));

        // Three button presses in one frame collapse into one advance
        btn_pulse();
        btn_pulse();
        btn_pulse();
        frame1(mk(2, 'h31, 0, 1));
        frame1(mk(2, 'h31, 1, 0));

        // Skip landing on the expiry tick: a single advance
        frame1(mk(2, 'h31, 2, 0));
        btn_pulse();
        frame1(mk(3, 'h31, 0, 1));

        // Pause across 5 ticks with a press; skip applies on release
        hold = 1'b1;
        repeat (4) @(negedge clk);
        frame1(mk(3, 'h31, 0, 0));
        frame1(mk(3, 'h31, 0, 0));
        btn_pulse();
        frame1(mk(3, 'h31, 0, 0));
        frame1(mk(3, 'h31, 0, 0));
        frame1(mk(3, 'h31, 0, 0));
        hold = 1'b0;
        repeat (4) @(negedge clk);
        frame1(mk(0, 'h30, 0, 1));

        // Walk to scene 2, pause with a skip pending, then reset with vsync high
        frame1(mk(0, 'h30, 1, 0));
        btn_pulse();
        frame1(mk(1, 'h30, 0, 1));
        btn_pulse();
        frame1(mk(2, 'h30, 0, 1));
        hold = 1'b1;
        repeat (4) @(negedge clk);
        frame1(mk(2, 'h30, 0, 0));
        btn_pulse();
        q1.push_back(mk(2, 'h30, 0, 0));
        @(negedge clk) vsync = 1'b1;
        repeat (6) @(negedge clk);
        q1.push_back(mk(0, 'h30, 0, 0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hold = 1'b0;
        repeat (12) @(negedge clk);
        vsync = 1'b0;
        repeat (6) @(negedge clk);
        // Skip was cleared by reset and no tick happened while vsync stayed high
        frame1(mk(0, 'h30, 1, 0));
        frame1(mk(0, 'h31, 2, 0));

        repeat (5) @(negedge clk);
        n_vec++;
        if (q1.size() != 0) begin
            n_err++;
            $display("FAIL dut_missing_updates: got %0d outstanding, required 0", q1.size());
        end
        n_vec++;
        if (q2.size() != 0) begin
            n_err++;
            $display("FAIL wrap_missing_updates: got %0d outstanding, required 0", q2.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
